// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq: streams Length+1 bytes between the TX/RX buffer RAMs and the
// flash or TF card SPI port (mode 0, MSB first), all in the FastClk domain.
module spi_xfer_seq #(
  parameter int BUF_AW     = 9,
  parameter int SLOW_DIV   = 32,
  parameter int WAIT_LIMIT = 256
) (
  input  logic              FastClk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Abort,
  input  logic [BUF_AW-1:0] Length,
  input  logic [1:0]        Mode,
  input  logic              DevSel,
  input  logic              Slow,
  output logic              Busy,
  output logic              Done,
  output logic              Timeout,
  output logic [BUF_AW-1:0] TxAddr,
  input  logic [7:0]        TxData,
  output logic [BUF_AW-1:0] RxAddr,
  output logic [7:0]        RxData,
  output logic              RxWe,
  output logic              FlashClk,
  output logic              FlashDo,
  input  logic              FlashDi,
  output logic              TfClk,
  output logic              TfDo,
  input  logic              TfDi
);

  localparam int DIV_W  = $clog2(SLOW_DIV);
  localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SLOW_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [BUF_AW-1:0]   len_q, len_d;
  logic [1:0]          mode_q, mode_d;
  logic                dev_q, dev_d;
  logic                slow_q, slow_d;
  logic [BUF_AW-1:0]   count_q, count_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                armed_q, armed_d;
  logic                timeout_q, timeout_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [3:0]          half_q, half_d;
  logic                clk_q, clk_d;
  logic                do_q, do_d;
  logic                first_q, first_d;
  logic [7:0]          tx_sr_q, tx_sr_d;
  logic [7:0]          rx_sr_q, rx_sr_d;

  logic                di_s;
  logic [7:0]          byte_s;
  logic                tick_s;
  logic                last_s;
  logic [WAIT_W-1:0]   wait_inc_s;
  logic                discard_s;
  logic                timeout_hit_s;
  logic                last_byte_s;
  logic                do_s;
  logic                busy_s;
  logic                done_s;
  logic                rx_we_s;

  // Shared decode: MISO of the selected device, byte to send, half-period tick.
  assign di_s          = dev_q ? TfDi : FlashDi;
  assign byte_s        = mode_q[0] ? 8'hFF : TxData;
  assign tick_s        = !slow_q || (div_q == DIV_LAST);
  assign last_s        = (half_q == 4'd15) && tick_s;
  assign wait_inc_s    = wait_q + WAIT_W'(1);
  assign discard_s     = (mode_q == 2'd3) && !armed_q && (rx_sr_q == 8'hFF);
  assign timeout_hit_s = discard_s && (wait_inc_s == WAIT_MAX);
  assign last_byte_s   = (count_q == len_q);

  // The RAM delivers the byte only in the first SHIFT cycle, so bit 7 is
  // routed straight through for that one cycle, then held in do_q.
  assign do_s = first_q ? byte_s[7] : do_q;

  // FSM state register.
  always_ff @(posedge FastClk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; Abort returns to IDLE from any active state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (Start && !Abort) state_d = S_LOAD;
        else                 state_d = S_IDLE;
      end
      S_LOAD: begin
        if (Abort) state_d = S_IDLE;
        else       state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (Abort)       state_d = S_IDLE;
        else if (last_s) state_d = S_STORE;
        else             state_d = S_SHIFT;
      end
      S_STORE: begin
        if (Abort) begin
          state_d = S_IDLE;
        end else if (discard_s) begin
          if (timeout_hit_s) state_d = S_DONE;
          else               state_d = S_LOAD;
        end else if (last_byte_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output decode: status flags and the RX write strobe.
  always_comb begin
    busy_s  = 1'b0;
    done_s  = 1'b0;
    rx_we_s = 1'b0;
    case (state_q)
      S_LOAD:  busy_s = 1'b1;
      S_SHIFT: busy_s = 1'b1;
      S_STORE: begin
        busy_s  = 1'b1;
        rx_we_s = (mode_q != 2'd0) && !discard_s;
      end
      S_DONE:  done_s = 1'b1;
      default: begin
        busy_s  = 1'b0;
        done_s  = 1'b0;
        rx_we_s = 1'b0;
      end
    endcase
  end

  // Datapath next-state: field latching, bit timing, shifting, byte counting.
  always_comb begin
    len_d     = len_q;
    mode_d    = mode_q;
    dev_d     = dev_q;
    slow_d    = slow_q;
    count_d   = count_q;
    wait_d    = wait_q;
    armed_d   = armed_q;
    timeout_d = timeout_q;
    div_d     = div_q;
    half_d    = half_q;
    clk_d     = clk_q;
    do_d      = do_q;
    first_d   = first_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    case (state_q)
      S_IDLE: begin
        clk_d   = 1'b0;
        do_d    = 1'b1;
        first_d = 1'b0;
        if (Start && !Abort) begin
          len_d     = Length;
          mode_d    = Mode;
          dev_d     = DevSel;
          slow_d    = Slow;
          count_d   = '0;
          wait_d    = '0;
          armed_d   = 1'b0;
          timeout_d = 1'b0;
        end else begin
          count_d = count_q;
        end
      end
      S_LOAD: begin
        div_d   = '0;
        half_d  = 4'd0;
        clk_d   = 1'b0;
        do_d    = 1'b1;
        first_d = !Abort;
      end
      S_SHIFT: begin
        first_d = 1'b0;
        if (Abort) begin
          clk_d = 1'b0;
          do_d  = 1'b1;
        end else begin
          if (first_q) begin
            tx_sr_d = byte_s;
            do_d    = byte_s[7];
          end else begin
            tx_sr_d = tx_sr_q;
          end
          if (tick_s) begin
            div_d  = '0;
            half_d = half_q + 4'd1;
            if (!half_q[0]) begin
              // End of a low half: rising SpiClk, capture MISO.
              clk_d   = 1'b1;
              rx_sr_d = {rx_sr_q[6:0], di_s};
            end else begin
              // End of a high half: falling SpiClk, present next bit.
              clk_d = 1'b0;
              if (half_q == 4'd15) begin
                do_d = 1'b1;
              end else begin
                tx_sr_d = {tx_sr_q[6:0], 1'b1};
                do_d    = tx_sr_q[6];
              end
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end
      S_STORE: begin
        if (Abort) begin
          count_d = count_q;
        end else if (discard_s) begin
          wait_d = wait_inc_s;
          if (timeout_hit_s) timeout_d = 1'b1;
          else               timeout_d = timeout_q;
        end else begin
          if (mode_q == 2'd3) armed_d = 1'b1;
          else                armed_d = armed_q;
          if (!last_byte_s) count_d = count_q + BUF_AW'(1);
          else              count_d = count_q;
        end
      end
      default: begin
        clk_d = 1'b0;
        do_d  = 1'b1;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge FastClk or posedge Reset) begin
    if (Reset) begin
      len_q     <= '0;
      mode_q    <= 2'd0;
      dev_q     <= 1'b0;
      slow_q    <= 1'b0;
      count_q   <= '0;
      wait_q    <= '0;
      armed_q   <= 1'b0;
      timeout_q <= 1'b0;
      div_q     <= '0;
      half_q    <= 4'd0;
      clk_q     <= 1'b0;
      do_q      <= 1'b1;
      first_q   <= 1'b0;
      tx_sr_q   <= 8'hFF;
      rx_sr_q   <= 8'h00;
    end else begin
      len_q     <= len_d;
      mode_q    <= mode_d;
      dev_q     <= dev_d;
      slow_q    <= slow_d;
      count_q   <= count_d;
      wait_q    <= wait_d;
      armed_q   <= armed_d;
      timeout_q <= timeout_d;
      div_q     <= div_d;
      half_q    <= half_d;
      clk_q     <= clk_d;
      do_q      <= do_d;
      first_q   <= first_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
    end
  end

  assign Busy     = busy_s;
  assign Done     = done_s;
  assign RxWe     = rx_we_s;
  assign Timeout  = timeout_q;
  assign TxAddr   = count_q;
  assign RxAddr   = count_q;
  assign RxData   = rx_sr_q;
  // The deselected device sees a parked bus: clock low, data high.
  assign FlashClk = clk_q & ~dev_q;
  assign TfClk    = clk_q & dev_q;
  assign FlashDo  = dev_q ? 1'b1 : do_s;
  assign TfDo     = dev_q ? do_s : 1'b1;

endmodule

// File: tb/tb_spi_xfer_seq.sv
// tb_spi_xfer_seq: random and directed transfers against a byte-level model,
// checked through a scoreboard of expected RX writes and Done events.
`timescale 1ns/1ps
module tb_spi_xfer_seq;
  localparam int AW = 9;
  localparam int SD = 32;
  localparam int WL = 6;

  logic          FastClk = 1'b0;
  logic          Reset, Start, Abort, DevSel, Slow;
  logic [AW-1:0] Length;
  logic [1:0]    Mode;
  logic          Busy, Done, Timeout, RxWe;
  logic [AW-1:0] TxAddr, RxAddr;
  logic [7:0]    TxData, RxData;
  logic          FlashClk, FlashDo, FlashDi, TfClk, TfDo, TfDi;

  spi_xfer_seq #(.BUF_AW(AW), .SLOW_DIV(SD), .WAIT_LIMIT(WL)) dut (
    .FastClk(FastClk), .Reset(Reset), .Start(Start), .Abort(Abort),
    .Length(Length), .Mode(Mode), .DevSel(DevSel), .Slow(Slow),
    .Busy(Busy), .Done(Done), .Timeout(Timeout),
    .TxAddr(TxAddr), .TxData(TxData), .RxAddr(RxAddr), .RxData(RxData), .RxWe(RxWe),
    .FlashClk(FlashClk), .FlashDo(FlashDo), .FlashDi(FlashDi),
    .TfClk(TfClk), .TfDo(TfDo), .TfDi(TfDi)
  );

  always #5 FastClk = ~FastClk;

  int cyc = 0;
  always @(posedge FastClk) cyc++;

  // Buffer RAMs: synchronous read TX, synchronous write RX.
  logic [7:0] tx_mem [0:511];
  logic [7:0] rx_mem [0:511];
  always @(posedge FastClk) TxData <= tx_mem[TxAddr];
  always @(posedge FastClk) if (RxWe) rx_mem[RxAddr] <= RxData;

  // Flash: MISO looped back to MOSI. TF card: shifts out tf_resp, changing on falling SCK.
  assign FlashDi = FlashDo;
  logic [7:0] tf_resp [0:31];
  int         tf_fall = 0;
  logic       tf_di;
  always @(negedge TfClk) tf_fall++;
  always_comb begin
    if (tf_fall < 256) tf_di = tf_resp[5'(tf_fall / 8)][3'(7 - (tf_fall % 8))];
    else               tf_di = 1'b1;
  end
  assign TfDi = tf_di;

  int fl_rise = 0, tf_rise = 0;
  bit fl_bits[$];
  int fl_time[$];
  always @(posedge FlashClk) begin fl_rise++; fl_bits.push_back(FlashDo); fl_time.push_back(cyc); end
  always @(posedge TfClk) tf_rise++;

  int checks = 0, errors = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard of expected DUT events.
  typedef struct { bit is_done; int addr; int data; int cyc; } ev_t;
  ev_t exp_q[$];
  ev_t ev;

  always @(negedge FastClk) begin
    if (!Reset) begin
      if (RxWe) begin
        check("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          ev = exp_q.pop_front();
          check("write_kind", ev.is_done, 0);
          check("write_addr", RxAddr, ev.addr);
          check("write_data", RxData, ev.data);
        end
      end
      if (Done) begin
        check("done_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          ev = exp_q.pop_front();
          check("done_kind", ev.is_done, 1);
          check("done_cycle", cyc, ev.cyc);
          check("done_timeout", Timeout, ev.data);
          check("done_busy", Busy, 0);
        end
      end
    end
  end

  // Byte-level model: walk the device's responses and apply the storing rules.
  logic [7:0] resp_m [0:63];
  task automatic predict(input int mode, input int len, input int slow, input int sc, output int nbytes);
    int count, waits, i;
    bit armed, to;
    logic [7:0] rx;
    ev_t e;
    count = 0; waits = 0; i = 0; armed = 0; to = 0;
    while (count <= len) begin
      rx = resp_m[i];
      i++;
      if (mode == 3 && !armed && rx == 8'hFF) begin
        waits++;
        if (waits == WL) begin to = 1; break; end
      end else begin
        if (mode == 3) armed = 1;
        if (mode != 0) begin
          e.is_done = 0; e.addr = count; e.data = rx; e.cyc = 0;
          exp_q.push_back(e);
        end
        count++;
      end
    end
    nbytes = i;
    e.is_done = 1; e.addr = 0; e.data = to;
    e.cyc = sc + i * (slow ? (2 + 16 * SD) : 18) + 1;
    exp_q.push_back(e);
  endtask

  task automatic launch(input int mode, input int len, input int dev, input int slow,
                        input bit pred, output int sc, output int nb);
    for (int i = 0; i < 64; i++) begin
      if (dev == 1) resp_m[i] = (i < 32) ? tf_resp[i] : 8'hFF;
      else          resp_m[i] = (mode % 2 == 1) ? 8'hFF : tx_mem[i];
    end
    tf_fall = 0; fl_rise = 0; tf_rise = 0;
    fl_bits.delete(); fl_time.delete();
    @(negedge FastClk);
    Length = AW'(len); Mode = 2'(mode); DevSel = 1'(dev); Slow = 1'(slow); Start = 1'b1;
    sc = cyc;
    nb = 0;
    if (pred) predict(mode, len, slow, sc, nb);
    @(negedge FastClk);
    Start = 1'b0;
    check("busy_after_start", Busy, 1);
    check("timeout_cleared", Timeout, 0);
  endtask

  task automatic wait_done(input int nb, input int dev);
    bit seen;
    seen = 0;
    for (int k = 0; k < 20000 && !seen; k++) begin
      @(negedge FastClk);
      if (Done) seen = 1;
    end
    check("done_seen", seen, 1);
    @(negedge FastClk);
    check("sb_drained", exp_q.size(), 0);
    check("flash_edges", fl_rise, (dev == 0) ? 8 * nb : 0);
    check("tf_edges", tf_rise, (dev == 1) ? 8 * nb : 0);
    check("idle_after_done", Busy, 0);
  endtask

  task automatic check_idle_pins(input string tag);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_done"}, Done, 0);
    check({tag, "_timeout"}, Timeout, 0);
    check({tag, "_rxwe"}, RxWe, 0);
    check({tag, "_txaddr"}, TxAddr, 0);
    check({tag, "_rxaddr"}, RxAddr, 0);
    check({tag, "_fclk"}, FlashClk, 0);
    check({tag, "_fdo"}, FlashDo, 1);
    check({tag, "_tclk"}, TfClk, 0);
    check({tag, "_tdo"}, TfDo, 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sc, nb, k;
    logic [7:0] t4_byte;
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0; DevSel = 1'b0; Slow = 1'b0;
    Length = '0; Mode = 2'd0;
    for (int i = 0; i < 32; i++) tf_resp[i] = 8'hFF;
    for (int i = 0; i < 512; i++) tx_mem[i] = 8'h00;
    repeat (3) @(negedge FastClk);
    check_idle_pins("reset");
    Reset = 1'b0;
    repeat (2) @(negedge FastClk);

    // T1: fast exchange on flash loopback, Done 73 cycles after Start.
    tx_mem[0] = 8'hA5; tx_mem[1] = 8'h3C; tx_mem[2] = 8'hFF; tx_mem[3] = 8'h00;
    launch(2, 3, 0, 0, 1, sc, nb);
    wait_done(nb, 0);
    for (int i = 0; i < 4; i++) check("t1_rx_mem", rx_mem[i], tx_mem[i]);

    // T2: TF wait-response, five 0xFF then 01 AA.
    for (int i = 0; i < 32; i++) tf_resp[i] = 8'hFF;
    tf_resp[5] = 8'h01; tf_resp[6] = 8'hAA;
    launch(3, 1, 1, 0, 1, sc, nb);
    wait_done(nb, 1);

    // T3: TF never answers -> timeout after WAIT_LIMIT bytes.
    for (int i = 0; i < 32; i++) tf_resp[i] = 8'hFF;
    launch(3, 2, 1, 0, 1, sc, nb);
    wait_done(nb, 1);
    check("t3_timeout_sticky", Timeout, 1);

    // T4: slow TX of 0x81, check bit order and SCK period.
    t4_byte = 8'h81;
    tx_mem[0] = t4_byte;
    launch(0, 0, 0, 1, 1, sc, nb);
    wait_done(nb, 0);
    check("t4_nbits", fl_bits.size(), 8);
    for (int i = 0; i < 8 && i < fl_bits.size(); i++) check("t4_bit", fl_bits[i], t4_byte[7 - i]);
    if (fl_time.size() >= 8) begin
      check("t4_period_first", fl_time[1] - fl_time[0], 2 * SD);
      check("t4_period_last", fl_time[7] - fl_time[6], 2 * SD);
    end

    // T5: Abort in the middle of byte 2 of an 8-byte exchange.
    for (int i = 0; i < 8; i++) tx_mem[i] = 8'($urandom);
    launch(2, 7, 0, 0, 0, sc, nb);
    for (int i = 0; i < 2; i++) begin
      ev.is_done = 0; ev.addr = i; ev.data = tx_mem[i]; ev.cyc = 0;
      exp_q.push_back(ev);
    end
    repeat (44) @(negedge FastClk);
    Abort = 1'b1;
    @(negedge FastClk);
    Abort = 1'b0;
    check("t5_busy", Busy, 0);
    check("t5_fclk", FlashClk, 0);
    check("t5_fdo", FlashDo, 1);
    repeat (40) @(negedge FastClk);
    check("t5_sb_drained", exp_q.size(), 0);
    check("t5_still_idle", Busy, 0);
    for (int i = 0; i < 2; i++) check("t5_rx_kept", rx_mem[i], tx_mem[i]);
    launch(2, 2, 0, 0, 1, sc, nb);
    wait_done(nb, 0);

    // T6a: Start while busy is ignored.
    for (int i = 0; i < 8; i++) tx_mem[i] = 8'($urandom);
    launch(2, 1, 0, 0, 1, sc, nb);
    repeat (4) @(negedge FastClk);
    Start = 1'b1; Length = AW'(5); Mode = 2'd0; DevSel = 1'b1;
    @(negedge FastClk);
    Start = 1'b0;
    wait_done(nb, 0);

    // T6b: Start together with Abort from IDLE does nothing.
    @(negedge FastClk);
    Start = 1'b1; Abort = 1'b1; Length = AW'(2); Mode = 2'd2; DevSel = 1'b0;
    @(negedge FastClk);
    Start = 1'b0; Abort = 1'b0;
    check("t6_startabort_busy", Busy, 0);
    repeat (30) @(negedge FastClk);
    check("t6_startabort_idle", Busy, 0);

    // T6c: asynchronous Reset in the middle of SHIFT.
    launch(2, 3, 0, 0, 0, sc, nb);
    repeat (9) @(negedge FastClk);
    #2 Reset = 1'b1;
    #1 check_idle_pins("midreset");
    @(negedge FastClk);
    Reset = 1'b0;
    repeat (3) @(negedge FastClk);
    check_idle_pins("after_reset");

    // Randomized transfers on both devices.
    for (int it = 0; it < 12; it++) begin
      int dev, mode, len, slow;
      dev  = $urandom_range(0, 1);
      len  = $urandom_range(0, 7);
      slow = ($urandom_range(0, 4) == 0) ? 1 : 0;
      if (slow == 1) len = $urandom_range(0, 1);
      mode = (dev == 0) ? $urandom_range(0, 2) : $urandom_range(0, 3);
      for (int i = 0; i < 32; i++) tx_mem[i] = 8'($urandom);
      if (mode == 3) begin
        k = $urandom_range(0, WL);
        for (int i = 0; i < 32; i++)
          tf_resp[i] = (i < k) ? 8'hFF : ((i == k) ? 8'($urandom_range(0, 254)) : 8'($urandom));
      end else begin
        for (int i = 0; i < 32; i++) tf_resp[i] = 8'($urandom);
      end
      launch(mode, len, dev, slow, 1, sc, nb);
      wait_done(nb, dev);
    end

    repeat (5) @(negedge FastClk);
    check("final_sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
